// File: rtl/rv32i_types.sv
// Shared types for the unified memory-port arbiter: FSM state encoding and the
// latched downstream request record.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } mem_arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  // The streak counter must hold MAX_D_STREAK itself, and it is never narrower than 1 bit.
  function automatic int streak_width(input int max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the memory-port arbiter: data requests win unless fetch
// has waited out MAX_D_STREAK consecutive data grants.
module mem_arb_pick
  import rv32i_types::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int SW           = streak_width(MAX_D_STREAK)
) (
  input  logic          i_pend_i,
  input  logic          d_pend_i,
  input  logic [SW-1:0] d_streak_i,
  output logic          grant_i_o,
  output logic          grant_d_o,
  output logic [SW-1:0] d_streak_o
);

  localparam logic [SW-1:0] MAX_S = SW'(MAX_D_STREAK);

  logic force_i;

  always_comb begin
    force_i    = i_pend_i && d_pend_i && (MAX_D_STREAK != 0) && (d_streak_i == MAX_S);
    grant_d_o  = d_pend_i && !force_i;
    grant_i_o  = i_pend_i && !grant_d_o;
    d_streak_o = d_streak_i;
    // The streak only counts data wins that actually held fetch back, and it saturates.
    if (grant_d_o) begin
      if (i_pend_i) begin
        d_streak_o = (d_streak_i < MAX_S) ? d_streak_i + SW'(1) : d_streak_i;
      end else begin
        d_streak_o = '0;
      end
    end else if (grant_i_o) begin
      d_streak_o = '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (imem) and the memory stage (dmem):
// latches the winner, holds it downstream until mem_resp, routes the response back.
//
// state  | meaning
// IDLE   | no request outstanding; winner chosen on the next edge
// BUSY_I | fetch request held on the memory port
// BUSY_D | data request held on the memory port
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        arb_busy
);

  localparam int SW = streak_width(MAX_D_STREAK);

  mem_arb_state_t state_q, state_d;
  mem_req_t       req_q, req_d;
  logic [SW-1:0]  d_streak_q, d_streak_d, pick_streak;
  logic           i_pend, d_pend, grant_i, grant_d, busy;

  assign i_pend = |imem_rmask;
  assign d_pend = (|dmem_rmask) || (|dmem_wmask);

  mem_arb_pick #(
    .MAX_D_STREAK (MAX_D_STREAK),
    .SW           (SW)
  ) u_pick (
    .i_pend_i   (i_pend),
    .d_pend_i   (d_pend),
    .d_streak_i (d_streak_q),
    .grant_i_o  (grant_i),
    .grant_d_o  (grant_d),
    .d_streak_o (pick_streak)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= '0;
      d_streak_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      d_streak_q <= d_streak_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    d_streak_d = d_streak_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d    = BUSY_D;
          req_d      = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};
          d_streak_d = pick_streak;
        end else if (grant_i) begin
          state_d    = BUSY_I;
          req_d      = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
          d_streak_d = pick_streak;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The port is driven only from the latched request; a stray mem_resp in IDLE goes nowhere.
  always_comb begin
    busy       = (state_q != IDLE);
    arb_busy   = busy;
    mem_addr   = busy ? req_q.addr  : 32'h0;
    mem_rmask  = busy ? req_q.rmask : 4'h0;
    mem_wmask  = busy ? req_q.wmask : 4'h0;
    mem_wdata  = busy ? req_q.wdata : 32'h0;
    imem_resp  = (state_q == BUSY_I) && mem_resp;
    dmem_resp  = (state_q == BUSY_D) && mem_resp;
    imem_rdata = imem_resp ? mem_rdata : 32'h0;
    dmem_rdata = dmem_resp ? mem_rdata : 32'h0;
  end

endmodule
